ir_key_dec: RTL and testbench

//  NEC key decoder, directly downstream of the IR receiver (ir_rx).

---
 rtl/ir_key_dec.sv | 161 ++++++++++++++++
 tb/tb_ir_key_dec.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_key_dec.sv
// NEC key decoder: validates received frames and turns frame/repeat strobes into press, auto-repeat and release events.
// Latency: every output is registered, so each event strobe appears 1 clk after the input strobe that causes it.
// Backpressure: none; input strobes are consumed on the cycle they arrive and output strobes are never stalled.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_frame/_vld        completed 32-bit NEC frame {addr, ~addr, cmd, ~cmd} and its 1-cycle strobe
//   i_repeat            1-cycle NEC repeat-code strobe
//   o_key, o_addr       last accepted command / address byte (held across release)
//   o_key_vld/_rpt      press or auto-repeat event strobe; _rpt = 0 press, 1 auto-repeat (sticky)
//   o_held, o_release   key-held level and hold-timeout strobe
//   o_frame_err/_cnt    bad-frame strobe and saturating bad-frame count
module ir_key_dec #(
    parameter int TICK_DIV = 50000,
    parameter int HOLD_MS  = 120,
    parameter int RPT_SKIP = 3,
    parameter int ADDR_CHK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_repeat,
    output logic [7:0]  o_key,
    output logic [7:0]  o_addr,
    output logic        o_key_vld,
    output logic        o_key_rpt,
    output logic        o_held,
    output logic        o_release,
    output logic        o_frame_err,
    output logic [7:0]  o_err_cnt
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam logic [7:0] SKIP8 = 8'(RPT_SKIP);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    rpt_cnt_q, rpt_cnt_d;
    logic [7:0]    key_q, key_d;
    logic [7:0]    addr_q, addr_d;
    logic          key_vld_q, key_vld_d;
    logic          key_rpt_q, key_rpt_d;
    logic          held_q, held_d;
    logic          release_q, release_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          cmd_ok, addr_ok, good, tick_1ms;
    logic [7:0]    rpt_inc, err_inc;

    assign cmd_ok   = (i_frame[15:8] ^ i_frame[7:0]) == 8'hFF;
    assign addr_ok  = (ADDR_CHK == 0) || ((i_frame[31:24] ^ i_frame[23:16]) == 8'hFF);
    assign good     = cmd_ok && addr_ok;
    assign tick_1ms = (presc_q == PW'(TICK_DIV - 1));
    assign rpt_inc  = (rpt_cnt_q == 8'hFF) ? 8'hFF : rpt_cnt_q + 8'd1;
    assign err_inc  = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        presc_d     = tick_1ms ? '0 : presc_q + PW'(1);
        hold_d      = hold_q;
        rpt_cnt_d   = rpt_cnt_q;
        key_d       = key_q;
        addr_d      = addr_q;
        key_vld_d   = 1'b0;
        key_rpt_d   = key_rpt_q;
        release_d   = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        // Priority: frame > repeat > timeout. A frame is handled identically in both states,
        // except that a bad frame while held also ends the hold.
        if (i_frame_vld) begin
            if (good) begin
                key_d     = i_frame[15:8];
                addr_d    = i_frame[31:24];
                key_vld_d = 1'b1;
                key_rpt_d = 1'b0;
                rpt_cnt_d = 8'd0;
                hold_d    = '0;
                presc_d   = '0;
                state_d   = ST_HELD;
            end else begin
                frame_err_d = 1'b1;
                err_cnt_d   = err_inc;
                if (state_q == ST_HELD) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
        end else if (state_q == ST_HELD) begin
            if (i_repeat) begin
                // Reload the hold window; the first RPT_SKIP repeats only keep the key alive.
                hold_d    = '0;
                presc_d   = '0;
                rpt_cnt_d = rpt_inc;
                if (rpt_inc > SKIP8) begin
                    key_vld_d = 1'b1;
                    key_rpt_d = 1'b1;
                end
            end else if (tick_1ms) begin
                if (hold_q == HW'(HOLD_MS - 1)) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end

        held_d = (state_d == ST_HELD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            hold_q      <= '0;
            rpt_cnt_q   <= 8'd0;
            key_q       <= 8'd0;
            addr_q      <= 8'd0;
            key_vld_q   <= 1'b0;
            key_rpt_q   <= 1'b0;
            held_q      <= 1'b0;
            release_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            rpt_cnt_q   <= rpt_cnt_d;
            key_q       <= key_d;
            addr_q      <= addr_d;
            key_vld_q   <= key_vld_d;
            key_rpt_q   <= key_rpt_d;
            held_q      <= held_d;
            release_q   <= release_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_key       = key_q;
    assign o_addr      = addr_q;
    assign o_key_vld   = key_vld_q;
    assign o_key_rpt   = key_rpt_q;
    assign o_held      = held_q;
    assign o_release   = release_q;
    assign o_frame_err = frame_err_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ir_key_dec.sv
// Testbench for ir_key_dec: directed vector table, multi-cycle corner sequences and randomized traffic.
// Latency: expects every output event one clk after the stimulus cycle.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_ir_key_dec;

    localparam int TD   = 8;     // short ms tick to keep the run small
    localparam int HOLD = 120;
    localparam int SKIP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_frame = 32'h0;
    logic        i_frame_vld = 1'b0;
    logic        i_repeat = 1'b0;

    logic [7:0]  o_key, o_addr, o_err_cnt;
    logic        o_key_vld, o_key_rpt, o_held, o_release, o_frame_err;
    logic [7:0]  b_key, b_addr, b_err_cnt;
    logic        b_key_vld, b_key_rpt, b_held, b_release, b_frame_err;

    always #5 clk = ~clk;

    ir_key_dec #(.TICK_DIV(TD), .HOLD_MS(HOLD), .RPT_SKIP(SKIP), .ADDR_CHK(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_frame_vld(i_frame_vld), .i_repeat(i_repeat),
        .o_key(o_key), .o_addr(o_addr), .o_key_vld(o_key_vld), .o_key_rpt(o_key_rpt), .o_held(o_held),
        .o_release(o_release), .o_frame_err(o_frame_err), .o_err_cnt(o_err_cnt)
    );

    // Extended-address variant: command complement only.
    ir_key_dec #(.TICK_DIV(TD), .HOLD_MS(HOLD), .RPT_SKIP(SKIP), .ADDR_CHK(0)) u_dut_ext (
        .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_frame_vld(i_frame_vld), .i_repeat(i_repeat),
        .o_key(b_key), .o_addr(b_addr), .o_key_vld(b_key_vld), .o_key_rpt(b_key_rpt), .o_held(b_held),
        .o_release(b_release), .o_frame_err(b_frame_err), .o_err_cnt(b_err_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (behavioural, time-based) ----------------
    logic [7:0] m_key = 8'h0, m_addr = 8'h0;
    bit         m_vld, m_rpt, m_held, m_rel, m_err;
    int         m_ecnt, m_rcnt, m_age;   // m_age: clock edges since the last press/repeat

    task automatic model(input logic rn, input logic [31:0] f, input logic fv, input logic rp);
        bit good;
        good  = (f[7:0] == ~f[15:8]) && (f[23:16] == ~f[31:24]);
        m_vld = 0; m_rel = 0; m_err = 0;
        if (!rn) begin
            m_key = 8'h0; m_addr = 8'h0; m_rpt = 0; m_held = 0;
            m_ecnt = 0; m_rcnt = 0; m_age = 0;
        end else if (fv) begin
            if (good) begin
                m_key = f[15:8]; m_addr = f[31:24];
                m_vld = 1; m_rpt = 0; m_rcnt = 0; m_age = 0; m_held = 1;
            end else begin
                m_err  = 1;
                m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
                if (m_held) begin m_rel = 1; m_held = 0; end
            end
        end else if (m_held) begin
            if (rp) begin
                m_age  = 0;
                m_rcnt = (m_rcnt < 255) ? m_rcnt + 1 : 255;
                if (m_rcnt > SKIP) begin m_vld = 1; m_rpt = 1; end
            end else begin
                m_age++;
                if (m_age == HOLD * TD) begin m_rel = 1; m_held = 0; end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_key"},   o_key,       m_key);
        check({tag, "_addr"},  o_addr,      m_addr);
        check({tag, "_vld"},   o_key_vld,   m_vld);
        check({tag, "_rpt"},   o_key_rpt,   m_rpt);
        check({tag, "_held"},  o_held,      m_held);
        check({tag, "_rel"},   o_release,   m_rel);
        check({tag, "_err"},   o_frame_err, m_err);
        check({tag, "_ecnt"},  o_err_cnt,   8'(m_ecnt));
    endtask

    // Drive one cycle of inputs, advance the model with the same inputs, sample #1 after the edge.
    task automatic step(input logic rn, input logic [31:0] f, input logic fv, input logic rp,
                        input bit chk, input string tag);
        rst_n = rn; i_frame = f; i_frame_vld = fv; i_repeat = rp;
        @(posedge clk);
        model(rn, f, fv, rp);
        #1;
        if (chk) check_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] k);
        return {a, ~a, k, ~k};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rn;
        logic [31:0] frame;
        logic        fv, rp;
        logic [7:0]  e_key, e_addr;
        logic        e_vld, e_rpt, e_held, e_rel, e_err;
        logic [7:0]  e_ecnt;
    } tvec_t;

    tvec_t tbl[15];

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int rel_at, n_evt, thr_f, thr_r, r;
        logic [31:0] f;

        //           rn    frame         fv  rp  key    addr   vld rpt held rel err ecnt
        tbl[0]  = '{1'b0, 32'h0,        0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0};
        tbl[1]  = '{1'b1, 32'h00FF45BA, 1, 0, 8'h45, 8'h00, 1, 0, 1, 0, 0, 8'd0};
        tbl[2]  = '{1'b1, 32'h0,        0, 0, 8'h45, 8'h00, 0, 0, 1, 0, 0, 8'd0};
        tbl[3]  = '{1'b1, 32'h00FF4545, 1, 0, 8'h45, 8'h00, 0, 0, 0, 1, 1, 8'd1};
        tbl[4]  = '{1'b1, 32'h0,        0, 1, 8'h45, 8'h00, 0, 0, 0, 0, 0, 8'd1};
        tbl[5]  = '{1'b1, 32'h123445BA, 1, 0, 8'h45, 8'h00, 0, 0, 0, 0, 1, 8'd2};
        tbl[6]  = '{1'b1, 32'h00FF16E9, 1, 0, 8'h16, 8'h00, 1, 0, 1, 0, 0, 8'd2};
        tbl[7]  = '{1'b1, 32'h00FF45BA, 1, 1, 8'h45, 8'h00, 1, 0, 1, 0, 0, 8'd2};
        tbl[8]  = '{1'b1, 32'h0,        0, 1, 8'h45, 8'h00, 0, 0, 1, 0, 0, 8'd2};
        tbl[9]  = '{1'b1, 32'h0,        0, 1, 8'h45, 8'h00, 0, 0, 1, 0, 0, 8'd2};
        tbl[10] = '{1'b1, 32'h0,        0, 1, 8'h45, 8'h00, 0, 0, 1, 0, 0, 8'd2};
        tbl[11] = '{1'b1, 32'h0,        0, 1, 8'h45, 8'h00, 1, 1, 1, 0, 0, 8'd2};
        tbl[12] = '{1'b1, 32'h0,        0, 0, 8'h45, 8'h00, 0, 1, 1, 0, 0, 8'd2};
        tbl[13] = '{1'b0, 32'h0,        0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0};
        tbl[14] = '{1'b1, 32'h0,        0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rn, tbl[i].frame, tbl[i].fv, tbl[i].rp, 1'b0, "");
            check($sformatf("tbl%0d_key", i),  o_key,       tbl[i].e_key);
            check($sformatf("tbl%0d_addr", i), o_addr,      tbl[i].e_addr);
            check($sformatf("tbl%0d_vld", i),  o_key_vld,   tbl[i].e_vld);
            check($sformatf("tbl%0d_rpt", i),  o_key_rpt,   tbl[i].e_rpt);
            check($sformatf("tbl%0d_held", i), o_held,      tbl[i].e_held);
            check($sformatf("tbl%0d_rel", i),  o_release,   tbl[i].e_rel);
            check($sformatf("tbl%0d_err", i),  o_frame_err, tbl[i].e_err);
            check($sformatf("tbl%0d_ecnt", i), o_err_cnt,   tbl[i].e_ecnt);
        end

        // ---- auto-repeat: 5 repeats at 108 ms spacing, events only on repeats 4 and 5 ----
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "ar_rst");
        step(1'b1, 32'h00FF45BA, 1'b1, 1'b0, 1'b1, "ar_press");
        n_evt = 0;
        for (int k = 1; k <= 5; k++) begin
            idle(108 * TD - 1, "ar_gap");
            step(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, "ar_rep");
            check($sformatf("ar_rep%0d_vld", k), o_key_vld, (k > SKIP) ? 1'b1 : 1'b0);
            check($sformatf("ar_rep%0d_held", k), o_held, 1'b1);
            if (o_key_vld && o_key_rpt) n_evt++;
        end
        check("ar_event_count", n_evt, 2);

        // ---- hold timeout: release exactly HOLD ticks after the press, key retained ----
        step(1'b1, 32'h00FF45BA, 1'b1, 1'b0, 1'b1, "to_press");
        rel_at = 0;
        for (int k = 1; k <= HOLD * TD + 10; k++) begin
            step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, "to_wait");
            if (o_release && rel_at == 0) rel_at = k;
        end
        check("to_release_cycle", rel_at, HOLD * TD);
        check("to_held_after", o_held, 1'b0);
        check("to_key_kept", o_key, 8'h45);

        // ---- repeat landing on the expiry cycle reloads instead of releasing ----
        step(1'b1, 32'h00FF16E9, 1'b1, 1'b0, 1'b1, "ex_press");
        idle(HOLD * TD - 1, "ex_wait");
        step(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, "ex_rep");
        check("ex_no_release", o_release, 1'b0);
        check("ex_still_held", o_held, 1'b1);
        idle(HOLD * TD - 1, "ex_wait2");
        check("ex_held_after_reload", o_held, 1'b1);

        // ---- bad-frame counter saturation ----
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "sat_rst");
        for (int k = 0; k < 260; k++) step(1'b1, 32'h00FF4545, 1'b1, 1'b0, 1'b0, "");
        check("sat_err_cnt", o_err_cnt, 8'd255);
        check("sat_err_strobe", o_frame_err, 1'b1);
        check("sat_no_key", o_key_vld, 1'b0);

        // ---- extended-address variant accepts a non-complemented address ----
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "ext_rst");
        step(1'b1, 32'h123445BA, 1'b1, 1'b0, 1'b1, "ext_frame");
        check("ext_vld", b_key_vld, 1'b1);
        check("ext_addr", b_addr, 8'h12);
        check("ext_key", b_key, 8'h45);
        check("ext_no_err", b_frame_err, 1'b0);

        // ---- randomized traffic against the model ----
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "rnd_rst");
        for (int blk = 0; blk < 8; blk++) begin
            // even blocks: busy traffic; odd blocks: sparse traffic so holds time out
            thr_f = (blk % 2 == 0) ? 60 : 5;
            thr_r = (blk % 2 == 0) ? 50 : 5;
            for (int c = 0; c < 2500; c++) begin
                r = int'($urandom_range(0, 9999));
                f = nec(8'($urandom), 8'($urandom));
                if ($urandom_range(0, 1) == 0) f[$urandom_range(0, 31)] ^= 1'b1;
                step((r >= 3) ? 1'b1 : 1'b0, f, (r < thr_f) ? 1'b1 : 1'b0,
                     (r >= 100 && r < 100 + thr_r) ? 1'b1 : 1'b0, 1'b1, "rnd");
            end
        end

        rst_n = 1'b1; i_frame_vld = 1'b0; i_repeat = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
